// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared fixed-point and complex-word constants for the FFT datapath
package fft_pkg;

  localparam int FIX_BIT = 7;
  localparam int BITS    = 16;
  localparam int CPLX_W  = 2 * BITS;

  // Field index within a complex word: field k occupies [k*bits +: bits]
  localparam int RE_FIELD = 0;
  localparam int IM_FIELD = 1;

endpackage

// File: rtl/cmul_conj.sv
// rtl/cmul_conj.sv - full-precision complex product a * conj(b), combinational
module cmul_conj
  import fft_pkg::*;
#(
  parameter int a_w = BITS + 1,
  parameter int b_w = BITS
) (
  input  logic signed [a_w-1:0]   a_re,
  input  logic signed [a_w-1:0]   a_im,
  input  logic signed [b_w-1:0]   b_re,
  input  logic signed [b_w-1:0]   b_im,
  output logic signed [a_w+b_w:0] p_re,
  output logic signed [a_w+b_w:0] p_im
);

  localparam int PW = a_w + b_w + 1;

  logic signed [PW-1:0] ar, ai, br, bi;

  assign ar = PW'(a_re);
  assign ai = PW'(a_im);
  assign br = PW'(b_re);
  assign bi = PW'(b_im);

  // (ar + j*ai) * (br - j*bi); true result always fits in PW bits
  assign p_re = (ar * br) + (ai * bi);
  assign p_im = (ai * br) - (ar * bi);

endmodule

// File: rtl/ifft_bfly_pipe.sv
// rtl/ifft_bfly_pipe.sv - 3-stage scaled DIF inverse butterfly with conjugate twiddle
module ifft_bfly_pipe
  import fft_pkg::*;
#(
  parameter int fix_bit = FIX_BIT,
  parameter int bits    = BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*bits-1:0] In0,
  input  logic [2*bits-1:0] In1,
  input  logic [2*bits-1:0] In_twiddle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*bits-1:0] Out0,
  output logic [2*bits-1:0] Out1,
  output logic              out_sat
);

  localparam int DW = bits + 1;
  localparam int PW = 2 * bits + 2;
  localparam logic signed [PW-1:0] MAX_V = $signed({{(PW-bits+1){1'b0}}, {(bits-1){1'b1}}});
  localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

  // Returns {clamped, value}: floor shift by fix_bit+1 then clamp to bits
  function automatic logic [bits:0] sat_shift(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] sh;
    sh = v >>> (fix_bit + 1);
    if (sh > MAX_V)      return {1'b1, 1'b0, {(bits-1){1'b1}}};
    else if (sh < MIN_V) return {1'b1, 1'b1, {(bits-1){1'b0}}};
    else                 return {1'b0, bits'(sh)};
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic signed [bits-1:0] x0_re, x0_im, x1_re, x1_im, w_re, w_im;
  assign x0_re = In0[RE_FIELD*bits +: bits];
  assign x0_im = In0[IM_FIELD*bits +: bits];
  assign x1_re = In1[RE_FIELD*bits +: bits];
  assign x1_im = In1[IM_FIELD*bits +: bits];

  // Stage 1: widened sum/difference
  logic                 s1_valid;
  logic signed [DW-1:0] s1_s_re, s1_s_im, s1_d_re, s1_d_im;
  logic [2*bits-1:0]    s1_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_s_re  <= '0;
      s1_s_im  <= '0;
      s1_d_re  <= '0;
      s1_d_im  <= '0;
      s1_w     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_s_re  <= {x0_re[bits-1], x0_re} + {x1_re[bits-1], x1_re};
      s1_s_im  <= {x0_im[bits-1], x0_im} + {x1_im[bits-1], x1_im};
      s1_d_re  <= {x0_re[bits-1], x0_re} - {x1_re[bits-1], x1_re};
      s1_d_im  <= {x0_im[bits-1], x0_im} - {x1_im[bits-1], x1_im};
      s1_w     <= In_twiddle;
    end
  end

  // Stage 2: halve the sum, conjugate-multiply the difference
  assign w_re = s1_w[RE_FIELD*bits +: bits];
  assign w_im = s1_w[IM_FIELD*bits +: bits];

  logic signed [PW-1:0] prod_re, prod_im;

  cmul_conj #(
    .a_w(DW),
    .b_w(bits)
  ) u_cmul_conj (
    .a_re(s1_d_re),
    .a_im(s1_d_im),
    .b_re(w_re),
    .b_im(w_im),
    .p_re(prod_re),
    .p_im(prod_im)
  );

  logic [2*bits-1:0] a_word;
  always_comb begin
    a_word = '0;
    a_word[RE_FIELD*bits +: bits] = bits'(s1_s_re >>> 1);
    a_word[IM_FIELD*bits +: bits] = bits'(s1_s_im >>> 1);
  end

  logic                 s2_valid;
  logic [2*bits-1:0]    s2_a;
  logic signed [PW-1:0] s2_br, s2_bi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_br    <= '0;
      s2_bi    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_a     <= a_word;
      s2_br    <= prod_re;
      s2_bi    <= prod_im;
    end
  end

  // Stage 3: rescale, saturate, register outputs
  logic [bits:0]     br_res, bi_res;
  logic [2*bits-1:0] b_word;
  logic              b_sat;

  always_comb begin
    br_res = sat_shift(s2_br);
    bi_res = sat_shift(s2_bi);
    b_word = '0;
    b_word[RE_FIELD*bits +: bits] = br_res[bits-1:0];
    b_word[IM_FIELD*bits +: bits] = bi_res[bits-1:0];
    b_sat  = br_res[bits] | bi_res[bits];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Out0      <= '0;
      Out1      <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      Out0      <= s2_a;
      Out1      <= b_word;
      out_sat   <= b_sat;
    end
  end

endmodule

// File: tb/tb_ifft_bfly_pipe.sv
// tb/tb_ifft_bfly_pipe.sv - scoreboard bench for ifft_bfly_pipe
module tb_ifft_bfly_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] In0, In1, In_twiddle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Out0, Out1;
  logic        out_sat;

  ifft_bfly_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In0       (In0),
    .In1       (In1),
    .In_twiddle(In_twiddle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out0      (Out0),
    .Out1      (Out1),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_out  = 0;
  int   cyc    = 0;
  bit   bp_rand = 1'b0;

  // Hand-computed vectors: inputs and expected A, B, saturation
  int x0r[8] = '{256, 100,  32767, -3, -32768,  32767, 10, 0};
  int x0i[8] = '{0,   50,   32767,  5, -32768, -32768, 20, 0};
  int x1r[8] = '{0,   20,  -32768,  0,  32767, -32768, 30, 0};
  int x1i[8] = '{0,  -10,  -32768,  0,  32767,  32767, -40, 0};
  int wr [8] = '{128,  0,    128, 128,    128,    128, 91, 0};
  int wi [8] = '{0,  128,    128,   0,    128,    128, -91, 0};
  int ar [8] = '{128, 60,     -1,  -2,     -1,     -1, 20, 0};
  int ai [8] = '{0,   20,     -1,   2,     -1,     -1, -10, 0};
  int br [8] = '{128, 30,  32767,  -2, -32768,      0, -29, 0};
  int bi [8] = '{0,  -40,      0,   2,      0, -32768, 14, 0};
  int st [8] = '{0,    0,      1,   0,      1,      1, 0, 0};

  function automatic logic [31:0] pk(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {i[15:0], r[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v);
    In0        = pk(x0r[v], x0i[v]);
    In1        = pk(x1r[v], x1i[v]);
    In_twiddle = pk(wr[v], wi[v]);
    in_valid   = 1'b1;
  endtask

  task automatic send(input int v);
    bit ok, done;
    exp_t e;
    done = 1'b0;
    drive(v);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) begin
        e.o0  = pk(ar[v], ai[v]);
        e.o1  = pk(br[v], bi[v]);
        e.sat = st[v][0];
        sb.push_back(e);
        done = 1'b1;
      end
    end
    #1;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: vector %0d not accepted, required acceptance", v);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on every output transfer and checks hold stability
  logic [31:0] h0, h1;
  logic        hs;
  bit          held = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        tests++;
        if (!out_valid || Out0 !== h0 || Out1 !== h1 || out_sat !== hs) begin
          fails++;
          $display("FAIL hold_stable: got v=%0b %h %h %b expected v=1 %h %h %b",
                   out_valid, Out0, Out1, out_sat, h0, h1, hs);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        n_out++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %h %h %b expected no result", Out0, Out1, out_sat);
        end else begin
          e = sb.pop_front();
          if (Out0 !== e.o0 || Out1 !== e.o1 || out_sat !== e.sat) begin
            fails++;
            $display("FAIL result: got %h %h sat=%b expected %h %h sat=%b",
                     Out0, Out1, out_sat, e.o0, e.o1, e.sat);
          end
        end
      end
      held = out_valid && !out_ready;
      h0 = Out0;
      h1 = Out1;
      hs = out_sat;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int t0, n0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    In0 = '0; In1 = '0; In_twiddle = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out0", 64'(Out0), 64'd0);
    chk("rst_out1", 64'(Out1), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: result visible exactly after edge k+2
    send(0);
    idle();
    @(posedge clk); #1;
    chk("lat_k1_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_k2_valid", 64'(out_valid), 64'd1);
    drain();

    for (int v = 0; v < 8; v++) send(v);
    idle();
    drain();

    // Random backpressure with bubbles
    bp_rand = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 8; v++) begin
        send(v);
        if ($urandom_range(0, 2) == 0) begin
          idle();
          @(posedge clk); #1;
        end
      end
    end
    idle();
    bp_rand = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Stall from reset: three accepted, fourth blocked until out_ready
    @(posedge clk); #1;
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = n_out;
    t0 = cyc;
    send(1); send(2); send(3);
    chk("stall_accept_edges", 64'(cyc - t0), 64'd3);
    drive(4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4);
    idle();
    drain();
    chk("stall_out_count", 64'(n_out - n0), 64'd4);

    // Reset with two results in flight
    send(6); send(7);
    idle();
    @(posedge clk); #1;
    chk("flight_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out0", 64'(Out0), 64'd0);
    chk("mid_rst_out1", 64'(Out1), 64'd0);
    chk("mid_rst_sat", 64'(out_sat), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifft_bfly_pipe.md
IFFT_BFLY_PIPE -- requirements
Module: ifft_bfly_pipe

Interface
REQ-001 Parameter fix_bit, default 7: number of fractional bits in every real/imag field (two's complement, Q(bits-fix_bit).fix_bit).
REQ-002 Parameter bits, default 16: width of one real or imag field; complex words are 2*bits wide.
REQ-003 Complex packing SHALL be real in [bits-1:0] and imag in [2*bits-1:bits] on every complex port.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  input triple valid.
REQ-007 in_ready  out  1  block accepts the triple this cycle.
REQ-008 In0  in  2*bits  butterfly top input X0.
REQ-009 In1  in  2*bits  butterfly bottom input X1.
REQ-010 In_twiddle  in  2*bits  twiddle W; the block SHALL apply conj(W).
REQ-011 out_valid  out  1  Out0/Out1 hold a result.
REQ-012 out_ready  in  1  downstream consumes the result this cycle.
REQ-013 Out0  out  2*bits  A = (X0+X1)/2.
REQ-014 Out1  out  2*bits  B = ((X0-X1)*conj(W))/2.
REQ-015 out_sat  out  1  B real or imag saturated for this result; qualified by out_valid.

Function
REQ-016 The block SHALL be the inverse (DIF, conjugate-twiddle, scaled by 1/2) of the DIT butterfly Out0=In0+W*In1, Out1=In0-W*In1, so that for |W|=1 feeding A,B,W into that butterfly returns X0,X1 to within 1 LSB.
REQ-017 Transfer on edge where in_valid&&in_ready (input) or out_valid&&out_ready (output).
REQ-018 Three register stages: S1 = sum/difference, S2 = conjugate products, S3 = output register.
REQ-019 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally; all stages hold when en=0.
REQ-020 A triple accepted at edge k SHALL appear on Out0/Out1 with out_valid=1 after edge k+2 when en stays 1.
REQ-021 Results SHALL leave in acceptance order, none dropped or duplicated under any out_ready pattern.
REQ-022 Bubbles (in_valid=0) SHALL propagate as per-stage valid=0 and never produce out_valid=1.
REQ-023 S1: S=X0+X1 and D=X0-X1 per field, bits+1 wide, no overflow.
REQ-024 A = S arithmetic-shifted right 1 (floor); always fits in bits.
REQ-025 S2: Br = Dr*Wr + Di*Wi, Bi = Di*Wr - Dr*Wi, full precision (2*bits+2 wide).
REQ-026 S3: B fields = arithmetic shift right by fix_bit+1 (floor), then saturate to [-2^(bits-1), 2^(bits-1)-1]; out_sat=1 if either field clamped.
REQ-027 Out0/Out1/out_sat SHALL remain stable while out_valid&&!out_ready.

Reset
REQ-028 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, Out0=0, Out1=0, out_sat=0, discarding in-flight data.
REQ-029 After rst_n rises, in_ready=1 and first acceptance is possible on the next edge; no pre-reset sample ever emerges.

Structure
REQ-030 Shared package fft_pkg SHALL hold FIX_BIT=7, BITS=16 defaults, complex-word width, and real/imag field index constants.
REQ-031 One sub-module cmul_conj SHALL compute the S2 conjugate product (combinational, widths parameterised).

Verification
REQ-032 X0=(256,0), X1=(0,0), W=(128,0), out_ready=1 -> after edge k+2 Out0=(128,0), Out1=(128,0), out_sat=0.
REQ-033 X0=(100,50), X1=(20,-10), W=(0,128) -> Out0=(60,20), Out1=(30,-40); feeding (60,20),(30,-40),W into the DIT butterfly returns (100,50),(20,-10).
REQ-034 X0=(32767,32767), X1=(-32768,-32768), W=(128,128) -> Out0=(-1,-1), Out1=(32767,0), out_sat=1.
REQ-035 out_ready=0 from reset, in_valid=1 with 4 distinct triples -> exactly 3 accepted (edges 0,1,2), in_ready=0 thereafter; on out_ready=1 the 4 results emerge in order, none lost/duplicated.
REQ-036 Two triples in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately, outputs 0; after release no result appears until a new triple is accepted.
